wb_pixel_readback: RTL and testbench
====================================

Name: wb_pixel_readback

Overview:
- Wishbone slave responder for the GPMC-to-Wishbone bridge, on the CPU-facing side of the display path.
- Terminates both read and write cycles from the bridge. Writes go to the display framebuffer or to control registers.
- Reads return framebuffer pixels through the pixel memory read port, or return register contents.
- Drives wbs_readdata and wbs_ack with deterministic latency, so the CPU can read back what it wrote.

Parameters:
- ADDR_W, 12, framebuffer address width; pixel space is wbs_address[ADDR_W-1:0] when wbs_address[12]=0.
- PIX_W, 12, pixel width; zero-extended to 16 bits on read.
- RAM_LAT, 1, pixel memory read latency in cycles (legal 1..3).
- ID_VALUE, 16'hB175, constant returned by the ID register.

Ports:
- clk  in  1  system clock (25 MHz domain from the clock manager)
- gls_reset  in  1  synchronous, active-high reset
- wbs_address  in  16  Wishbone address
- wbs_writedata  in  16  Wishbone write data
- wbs_readdata  out  16  Wishbone read data
- wbs_strobe  in  1  Wishbone strobe
- wbs_cycle  in  1  Wishbone cycle
- wbs_write  in  1  1=write, 0=read
- wbs_ack  out  1  one-cycle acknowledge
- pix_w_addr  out  ADDR_W  framebuffer write address
- pix_w_data  out  PIX_W  framebuffer write data
- pix_w_en  out  1  one-cycle framebuffer write enable
- mem_r_addr  out  ADDR_W  pixel memory read address
- mem_r_en  out  1  one-cycle read enable
- mem_r_data  in  PIX_W  pixel memory read data, valid RAM_LAT cycles after mem_r_en
- frame_count  in  16  free-running frame counter from the display controller
- ctrl_enable  out  1  display enable
- ctrl_bright  out  4  global brightness

Behaviour:
- A request is strobe & cycle, sampled only in IDLE.
- Register map (wbs_address[12]=1, decode on [1:0]):
  - 0 CTRL R/W: bit0=enable, bits7:4=bright.
  - 1 STATUS RO: returns frame_count.
  - 2 ID RO: returns ID_VALUE.
  - 3 SCRATCH R/W: 16 bits.
  - Writes to RO registers are acked and ignored. Reads of unused bits return 0.
- FSM states: IDLE, MEM_WAIT, ACK, RELEASE.
- IDLE, request present:
  - Pixel write: pix_w_addr/pix_w_data/pix_w_en=1 next cycle; go to ACK.
  - Register write: register updates next cycle; go to ACK.
  - Register read: readdata loaded next cycle; go to ACK.
  - Pixel read: mem_r_en=1 and mem_r_addr next cycle; go to MEM_WAIT with counter=RAM_LAT.
- MEM_WAIT: decrement the counter. When it expires, capture {0, mem_r_data} into wbs_readdata; go to ACK.
- ACK: wbs_ack=1 for exactly one cycle, then go to RELEASE.
- RELEASE: stay until strobe & cycle are both low, then go to IDLE. A held strobe never produces a second transaction.
- Latency from request sampled to ack:
  - Writes and register reads: 2 cycles.
  - Pixel reads: RAM_LAT+2 cycles.
- wbs_readdata holds its value from ack until the next read capture. Writes do not alter it.
- pix_w_en and mem_r_en are single-cycle pulses and never assert together.
- Mid-transaction deassertion: a cycle dropped in MEM_WAIT still completes internally. The ack is still issued, then the FSM returns to IDLE through RELEASE.
- Reset (gls_reset=1, synchronous, active-high):
  - State returns to IDLE from any state; an in-flight read is discarded with no ack.
  - Output reset values: wbs_ack=0, wbs_readdata=0, pix_w_en=0, mem_r_en=0, pix_w_addr=0, pix_w_data=0, mem_r_addr=0, ctrl_enable=0, ctrl_bright=4'hF.
  - SCRATCH resets to 0.
- Address bits [15:13] are ignored.

Decomposition:
- Shared package (display_pkg): FSM state encoding, register offsets, ID_VALUE, bright reset value.
- One natural sub-module, wb_regfile: CTRL/SCRATCH storage plus read mux, instantiated by wb_pixel_readback.

Test Plan:
- Reset: gls_reset high 3 cycles -> ack=0, readdata=0, ctrl_enable=0, ctrl_bright=F, SCRATCH reads 0.
- Pixel write: addr 0x0123, data 0x0ABC -> pix_w_en one pulse with addr 0x123, data 0xABC; ack 2 cycles after request.
- Pixel read, RAM_LAT=1: model returns 0x0ABC for addr 0x123 -> readdata=0x0ABC, ack 3 cycles after request. Repeat with RAM_LAT=3 -> ack at 5 cycles.
- Registers: write SCRATCH 0xDEAD, write CTRL 0x00A1 -> read SCRATCH=0xDEAD, CTRL=0x00A1, ID=0xB175, STATUS=frame_count (drive 0x0042); ctrl_enable=1, ctrl_bright=A.
- Held strobe: keep strobe/cycle high 10 cycles on a write -> exactly one pix_w_en pulse and one ack.
- Reset in MEM_WAIT: assert gls_reset 1 cycle after mem_r_en with RAM_LAT=3 -> no ack; FSM idle; next read completes normally.

Source files
------------

// File: rtl/display_pkg.sv
// ----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the CPU-facing display responder:
//   - FSM state encoding of the Wishbone responder
//   - register offsets within the register window (address bit 12 set)
//   - default ID register value and brightness reset value
// ----------------------------------------------------------------------------
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ACK      = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_ID      = 2'd2;
    localparam logic [1:0] REG_SCRATCH = 2'd3;

    localparam logic [15:0] DEF_ID_VALUE = 16'hB175;
    localparam logic [3:0]  BRIGHT_RST   = 4'hF;

    // Address bit 12 selects the register window; below it lives pixel space.
    function automatic logic is_reg_space(input logic [15:0] addr);
        return addr[12];
    endfunction

endpackage

// File: rtl/wb_pixel_readback_if.sv
// ----------------------------------------------------------------------------
// wb_pixel_readback_if
// Wishbone bus between the GPMC bridge (master) and the pixel readback
// responder (slave).
//   wbs_address   master->slave  16  byte-less word address
//   wbs_writedata master->slave  16  write data
//   wbs_strobe    master->slave   1  strobe
//   wbs_cycle     master->slave   1  cycle
//   wbs_write     master->slave   1  1=write, 0=read
//   wbs_readdata  slave->master  16  read data
//   wbs_ack       slave->master   1  one-cycle acknowledge
// ----------------------------------------------------------------------------
interface wb_pixel_readback_if;

    logic [15:0] wbs_address;
    logic [15:0] wbs_writedata;
    logic [15:0] wbs_readdata;
    logic        wbs_strobe;
    logic        wbs_cycle;
    logic        wbs_write;
    logic        wbs_ack;

    modport master (
        output wbs_address, wbs_writedata, wbs_strobe, wbs_cycle, wbs_write,
        input  wbs_readdata, wbs_ack
    );

    modport slave (
        input  wbs_address, wbs_writedata, wbs_strobe, wbs_cycle, wbs_write,
        output wbs_readdata, wbs_ack
    );

endinterface

// File: rtl/wb_regfile.sv
// ----------------------------------------------------------------------------
// wb_regfile
// CTRL / SCRATCH storage and the register read mux for the readback block.
//   clk           in   1  system clock
//   gls_reset     in   1  synchronous active-high reset
//   i_wr_en       in   1  register write strobe (one cycle)
//   i_sel         in   2  register offset
//   i_wdata       in  16  write data
//   i_frame_count in  16  live frame counter, returned by STATUS
//   o_rdata       out 16  combinational read data for offset i_sel
//   o_ctrl_enable out  1  display enable (CTRL bit 0)
//   o_ctrl_bright out  4  brightness (CTRL bits 7:4)
// ----------------------------------------------------------------------------
module wb_regfile
    import display_pkg::*;
#(
    parameter logic [15:0] ID_VALUE = DEF_ID_VALUE
) (
    input  logic        clk,
    input  logic        gls_reset,
    input  logic        i_wr_en,
    input  logic [1:0]  i_sel,
    input  logic [15:0] i_wdata,
    input  logic [15:0] i_frame_count,
    output logic [15:0] o_rdata,
    output logic        o_ctrl_enable,
    output logic [3:0]  o_ctrl_bright
);

    logic        r_enable;
    logic [3:0]  r_bright;
    logic [15:0] r_scratch;

    // STATUS and ID are read-only; writes to them fall through the default.
    always_ff @(posedge clk) begin
        if (gls_reset) begin
            r_enable  <= 1'b0;
            r_bright  <= BRIGHT_RST;
            r_scratch <= 16'h0000;
        end else if (i_wr_en) begin
            case (i_sel)
                REG_CTRL: begin
                    r_enable <= i_wdata[0];
                    r_bright <= i_wdata[7:4];
                end
                REG_SCRATCH: r_scratch <= i_wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        o_rdata = 16'h0000;
        case (i_sel)
            REG_CTRL:    o_rdata = {8'h00, r_bright, 3'b000, r_enable};
            REG_STATUS:  o_rdata = i_frame_count;
            REG_ID:      o_rdata = ID_VALUE;
            REG_SCRATCH: o_rdata = r_scratch;
            default:     o_rdata = 16'h0000;
        endcase
    end

    assign o_ctrl_enable = r_enable;
    assign o_ctrl_bright = r_bright;

endmodule

// File: rtl/wb_pixel_readback.sv
// ----------------------------------------------------------------------------
// wb_pixel_readback
// Wishbone slave terminating reads and writes from the GPMC bridge. Pixel
// space (address bit 12 = 0) goes to the framebuffer write port / pixel
// memory read port; the register window (bit 12 = 1) goes to wb_regfile.
//   clk          in   1       system clock
//   gls_reset    in   1       synchronous active-high reset
//   wbs          slave        Wishbone bus (wb_pixel_readback_if.slave)
//   pix_w_addr   out  ADDR_W  framebuffer write address
//   pix_w_data   out  PIX_W   framebuffer write data
//   pix_w_en     out  1       framebuffer write pulse
//   mem_r_addr   out  ADDR_W  pixel memory read address
//   mem_r_en     out  1       pixel memory read pulse
//   mem_r_data   in   PIX_W   read data, valid RAM_LAT cycles after mem_r_en
//   frame_count  in   16      frame counter, returned by STATUS
//   ctrl_enable  out  1       display enable
//   ctrl_bright  out  4       global brightness
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for strobe & cycle; decodes and launches the access
// MEM_WAIT  | counting down pixel memory latency, then captures read data
// ACK       | raises wbs_ack for the following cycle
// RELEASE   | ack visible; waits for strobe and cycle both low
// ----------------------------------------------------------------------------
module wb_pixel_readback
    import display_pkg::*;
#(
    parameter int          ADDR_W   = 12,
    parameter int          PIX_W    = 12,
    parameter int          RAM_LAT  = 1,
    parameter logic [15:0] ID_VALUE = DEF_ID_VALUE
) (
    input  logic                clk,
    input  logic                gls_reset,
    wb_pixel_readback_if.slave  wbs,
    output logic [ADDR_W-1:0]   pix_w_addr,
    output logic [PIX_W-1:0]    pix_w_data,
    output logic                pix_w_en,
    output logic [ADDR_W-1:0]   mem_r_addr,
    output logic                mem_r_en,
    input  logic [PIX_W-1:0]    mem_r_data,
    input  logic [15:0]         frame_count,
    output logic                ctrl_enable,
    output logic [3:0]          ctrl_bright
);

    state_t             r_state;
    logic [1:0]         r_cnt;
    logic               r_ack;
    logic [15:0]        r_readdata;
    logic [ADDR_W-1:0]  r_pix_w_addr;
    logic [PIX_W-1:0]   r_pix_w_data;
    logic               r_pix_w_en;
    logic [ADDR_W-1:0]  r_mem_r_addr;
    logic               r_mem_r_en;

    logic               w_req;
    logic               w_reg_sel;
    logic               w_reg_wr;
    logic [15:0]        w_reg_rdata;
    logic               w_unused_addr;

    assign w_req     = wbs.wbs_strobe & wbs.wbs_cycle;
    assign w_reg_sel = is_reg_space(wbs.wbs_address);
    assign w_reg_wr  = (r_state == ST_IDLE) & w_req & wbs.wbs_write & w_reg_sel;

    // Upper address bits alias onto the same pixel/register space.
    assign w_unused_addr = ^wbs.wbs_address[15:13];

    wb_regfile #(
        .ID_VALUE (ID_VALUE)
    ) u_regfile (
        .clk           (clk),
        .gls_reset     (gls_reset),
        .i_wr_en       (w_reg_wr),
        .i_sel         (wbs.wbs_address[1:0]),
        .i_wdata       (wbs.wbs_writedata),
        .i_frame_count (frame_count),
        .o_rdata       (w_reg_rdata),
        .o_ctrl_enable (ctrl_enable),
        .o_ctrl_bright (ctrl_bright)
    );

    always_ff @(posedge clk) begin
        if (gls_reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 2'd0;
            r_ack        <= 1'b0;
            r_readdata   <= 16'h0000;
            r_pix_w_addr <= '0;
            r_pix_w_data <= '0;
            r_pix_w_en   <= 1'b0;
            r_mem_r_addr <= '0;
            r_mem_r_en   <= 1'b0;
        end else begin
            r_ack      <= 1'b0;
            r_pix_w_en <= 1'b0;
            r_mem_r_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        if (w_reg_sel) begin
                            if (!wbs.wbs_write) begin
                                r_readdata <= w_reg_rdata;
                            end
                            r_state <= ST_ACK;
                        end else if (wbs.wbs_write) begin
                            r_pix_w_addr <= wbs.wbs_address[ADDR_W-1:0];
                            r_pix_w_data <= wbs.wbs_writedata[PIX_W-1:0];
                            r_pix_w_en   <= 1'b1;
                            r_state      <= ST_ACK;
                        end else begin
                            r_mem_r_addr <= wbs.wbs_address[ADDR_W-1:0];
                            r_mem_r_en   <= 1'b1;
                            r_cnt        <= 2'(RAM_LAT);
                            r_state      <= ST_MEM_WAIT;
                        end
                    end
                end
                // The counter reaches 1 on the edge at which memory data is
                // valid, so MEM_WAIT lasts exactly RAM_LAT cycles. The bus
                // is not watched here: a dropped cycle still completes.
                ST_MEM_WAIT: begin
                    if (r_cnt == 2'd1) begin
                        r_readdata <= {{(16-PIX_W){1'b0}}, mem_r_data};
                        r_state    <= ST_ACK;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                ST_ACK: begin
                    r_ack   <= 1'b1;
                    r_state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!wbs.wbs_strobe && !wbs.wbs_cycle) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wbs.wbs_ack      = r_ack;
    assign wbs.wbs_readdata = r_readdata;
    assign pix_w_addr       = r_pix_w_addr;
    assign pix_w_data       = r_pix_w_data;
    assign pix_w_en         = r_pix_w_en;
    assign mem_r_addr       = r_mem_r_addr;
    assign mem_r_en         = r_mem_r_en;

endmodule

// File: tb/tb_wb_pixel_readback.sv
// ----------------------------------------------------------------------------
// tb_wb_pixel_readback
// Two responders share clock and reset: u_dut_a with RAM_LAT=1 (index 0)
// and u_dut_b with RAM_LAT=3 (index 1). Each has its own pixel memory model
// whose read data is only meaningful in the cycle the responder should
// sample it; other cycles return 12'hEEE.
// ----------------------------------------------------------------------------
module tb_wb_pixel_readback;
    import display_pkg::*;

    typedef struct {
        logic [15:0] data;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        gls_reset = 1'b1;
    logic [15:0] frame_count = 16'h0042;
    int          cyc = 0;

    wb_pixel_readback_if bus_a ();
    wb_pixel_readback_if bus_b ();

    logic [11:0] pix_w_addr_a, pix_w_addr_b, mem_r_addr_a, mem_r_addr_b;
    logic [11:0] pix_w_data_a, pix_w_data_b, mem_r_data_a, mem_r_data_b;
    logic        pix_w_en_a, pix_w_en_b, mem_r_en_a, mem_r_en_b;
    logic        ctrl_enable_a, ctrl_enable_b;
    logic [3:0]  ctrl_bright_a, ctrl_bright_b;

    logic [11:0] mem_a [0:4095];
    logic [11:0] mem_b [0:4095];
    logic [11:0] pd0 = 12'h0, pd1 = 12'h0;
    logic        pv0 = 1'b0, pv1 = 1'b0;

    int          pix_cnt [2] = '{0, 0};
    int          mrd_cnt [2] = '{0, 0};
    int          ack_cnt [2] = '{0, 0};
    int          overlap_cnt = 0;
    logic [11:0] last_pix_addr [2];
    logic [11:0] last_pix_data [2];
    logic [11:0] last_mrd_addr [2];

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass = 0;

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wb_pixel_readback #(.ADDR_W(12), .PIX_W(12), .RAM_LAT(1), .ID_VALUE(16'hB175)) u_dut_a (
        .clk(clk), .gls_reset(gls_reset), .wbs(bus_a),
        .pix_w_addr(pix_w_addr_a), .pix_w_data(pix_w_data_a), .pix_w_en(pix_w_en_a),
        .mem_r_addr(mem_r_addr_a), .mem_r_en(mem_r_en_a), .mem_r_data(mem_r_data_a),
        .frame_count(frame_count), .ctrl_enable(ctrl_enable_a), .ctrl_bright(ctrl_bright_a)
    );

    wb_pixel_readback #(.ADDR_W(12), .PIX_W(12), .RAM_LAT(3), .ID_VALUE(16'hB175)) u_dut_b (
        .clk(clk), .gls_reset(gls_reset), .wbs(bus_b),
        .pix_w_addr(pix_w_addr_b), .pix_w_data(pix_w_data_b), .pix_w_en(pix_w_en_b),
        .mem_r_addr(mem_r_addr_b), .mem_r_en(mem_r_en_b), .mem_r_data(mem_r_data_b),
        .frame_count(frame_count), .ctrl_enable(ctrl_enable_b), .ctrl_bright(ctrl_bright_b)
    );

    // Pixel memory models: latency 1 reads straight off the launched address,
    // latency 3 adds two register stages.
    always @(posedge clk) begin
        if (pix_w_en_a) mem_a[pix_w_addr_a] <= pix_w_data_a;
        if (pix_w_en_b) mem_b[pix_w_addr_b] <= pix_w_data_b;
        pv0 <= mem_r_en_b;
        pd0 <= mem_b[mem_r_addr_b];
        pv1 <= pv0;
        pd1 <= pd0;
    end
    assign mem_r_data_a = mem_r_en_a ? mem_a[mem_r_addr_a] : 12'hEEE;
    assign mem_r_data_b = pv1 ? pd1 : 12'hEEE;

    always @(negedge clk) begin
        if (pix_w_en_a) begin pix_cnt[0]++; last_pix_addr[0] = pix_w_addr_a; last_pix_data[0] = pix_w_data_a; end
        if (pix_w_en_b) begin pix_cnt[1]++; last_pix_addr[1] = pix_w_addr_b; last_pix_data[1] = pix_w_data_b; end
        if (mem_r_en_a) begin mrd_cnt[0]++; last_mrd_addr[0] = mem_r_addr_a; end
        if (mem_r_en_b) begin mrd_cnt[1]++; last_mrd_addr[1] = mem_r_addr_b; end
        if (bus_a.wbs_ack) ack_cnt[0]++;
        if (bus_b.wbs_ack) ack_cnt[1]++;
        if ((pix_w_en_a && mem_r_en_a) || (pix_w_en_b && mem_r_en_b)) overlap_cnt++;
    end

    task automatic set_bus(input int sel, input logic s, input logic c, input logic we,
                           input logic [15:0] a, input logic [15:0] d);
        if (sel == 0) begin
            bus_a.wbs_strobe = s; bus_a.wbs_cycle = c; bus_a.wbs_write = we;
            bus_a.wbs_address = a; bus_a.wbs_writedata = d;
        end else begin
            bus_b.wbs_strobe = s; bus_b.wbs_cycle = c; bus_b.wbs_write = we;
            bus_b.wbs_address = a; bus_b.wbs_writedata = d;
        end
    endtask

    function automatic logic get_ack(input int sel);
        return (sel == 0) ? bus_a.wbs_ack : bus_b.wbs_ack;
    endfunction

    function automatic logic [15:0] get_rd(input int sel);
        return (sel == 0) ? bus_a.wbs_readdata : bus_b.wbs_readdata;
    endfunction

    // One complete bus transaction; lat is cycles from request to ack, -1 on timeout.
    task automatic do_txn(input int sel, input logic we, input logic [15:0] a,
                          input logic [15:0] d, output logic [15:0] rd, output int lat);
        int start;
        rd = 16'h0;
        lat = -1;
        @(posedge clk); #1;
        set_bus(sel, 1'b1, 1'b1, we, a, d);
        start = cyc;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (get_ack(sel)) begin
                rd = get_rd(sel);
                lat = cyc - start;
                break;
            end
        end
        @(posedge clk); #1;
        set_bus(sel, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic test_reset();
        logic [15:0] rd;
        int lat;
        exp_t e;
        repeat (3) @(posedge clk);
        #1 gls_reset = 1'b0;
        n_checks++; if (bus_a.wbs_ack !== 1'b0 || bus_b.wbs_ack !== 1'b0) $display("FAIL reset_ack: got %b%b expected 00", bus_a.wbs_ack, bus_b.wbs_ack); else n_pass++;
        n_checks++; if (bus_a.wbs_readdata !== 16'h0) $display("FAIL reset_readdata: got %h expected 0000", bus_a.wbs_readdata); else n_pass++;
        n_checks++; if (ctrl_enable_a !== 1'b0) $display("FAIL reset_enable: got %b expected 0", ctrl_enable_a); else n_pass++;
        n_checks++; if (ctrl_bright_a !== 4'hF) $display("FAIL reset_bright: got %h expected f", ctrl_bright_a); else n_pass++;
        sb.push_back('{16'h0000, 2});
        do_txn(0, 1'b0, 16'h1003, 16'h0, rd, lat);
        e = sb.pop_front();
        n_checks++; if (rd !== e.data || lat != e.lat) $display("FAIL reset_scratch: got %h lat %0d expected %h lat %0d", rd, lat, e.data, e.lat); else n_pass++;
    endtask

    task automatic test_pixel_write(input int sel);
        logic [15:0] rd;
        int lat, pc;
        pc = pix_cnt[sel];
        do_txn(sel, 1'b1, 16'h0123, 16'h0ABC, rd, lat);
        n_checks++; if (lat != 2) $display("FAIL pix_write_lat[%0d]: got %0d expected 2", sel, lat); else n_pass++;
        n_checks++; if (pix_cnt[sel] - pc != 1 || last_pix_addr[sel] !== 12'h123 || last_pix_data[sel] !== 12'hABC)
            $display("FAIL pix_write[%0d]: got pulses %0d addr %h data %h expected 1 123 abc", sel, pix_cnt[sel] - pc, last_pix_addr[sel], last_pix_data[sel]); else n_pass++;
        // Upper address bits alias; upper data bits are dropped.
        do_txn(sel, 1'b1, 16'hEFFF, 16'hFFFF, rd, lat);
        n_checks++; if (last_pix_addr[sel] !== 12'hFFF || last_pix_data[sel] !== 12'hFFF || lat != 2)
            $display("FAIL pix_write_edge[%0d]: got addr %h data %h lat %0d expected fff fff 2", sel, last_pix_addr[sel], last_pix_data[sel], lat); else n_pass++;
    endtask

    task automatic test_pixel_read(input int sel);
        logic [15:0] rd;
        int lat, mc, el;
        exp_t e;
        el = (sel == 0) ? 3 : 5;
        mc = mrd_cnt[sel];
        sb.push_back('{16'h0ABC, el});
        do_txn(sel, 1'b0, 16'h0123, 16'h0, rd, lat);
        e = sb.pop_front();
        n_checks++; if (rd !== e.data || lat != e.lat) $display("FAIL pix_read[%0d]: got %h lat %0d expected %h lat %0d", sel, rd, lat, e.data, e.lat); else n_pass++;
        n_checks++; if (mrd_cnt[sel] - mc != 1 || last_mrd_addr[sel] !== 12'h123)
            $display("FAIL mem_r_en[%0d]: got pulses %0d addr %h expected 1 123", sel, mrd_cnt[sel] - mc, last_mrd_addr[sel]); else n_pass++;
        sb.push_back('{16'h0FFF, el});
        do_txn(sel, 1'b0, 16'hEFFF, 16'h0, rd, lat);
        e = sb.pop_front();
        n_checks++; if (rd !== e.data || lat != e.lat) $display("FAIL pix_read_edge[%0d]: got %h lat %0d expected %h lat %0d", sel, rd, lat, e.data, e.lat); else n_pass++;
    endtask

    task automatic test_registers();
        logic [15:0] rd;
        int lat;
        exp_t e;
        do_txn(0, 1'b1, 16'h1003, 16'hDEAD, rd, lat);
        n_checks++; if (lat != 2) $display("FAIL reg_write_lat: got %0d expected 2", lat); else n_pass++;
        do_txn(0, 1'b1, 16'h1000, 16'h00A1, rd, lat);
        do_txn(0, 1'b1, 16'h1002, 16'h1234, rd, lat);
        n_checks++; if (ctrl_enable_a !== 1'b1 || ctrl_bright_a !== 4'hA) $display("FAIL ctrl_out: got %b %h expected 1 a", ctrl_enable_a, ctrl_bright_a); else n_pass++;
        sb.push_back('{16'hDEAD, 2});
        sb.push_back('{16'h00A1, 2});
        sb.push_back('{16'hB175, 2});
        sb.push_back('{16'h0042, 2});
        for (int i = 0; i < 4; i++) begin
            logic [15:0] a;
            case (i)
                0: a = 16'h1003;
                1: a = 16'h1000;
                2: a = 16'h1002;
                default: a = 16'hF001;
            endcase
            do_txn(0, 1'b0, a, 16'h0, rd, lat);
            e = sb.pop_front();
            n_checks++; if (rd !== e.data || lat != e.lat) $display("FAIL reg_read_%0d: got %h lat %0d expected %h lat %0d", i, rd, lat, e.data, e.lat); else n_pass++;
        end
        // A write leaves the last read value on the bus.
        do_txn(0, 1'b1, 16'h1000, 16'hFFFF, rd, lat);
        n_checks++; if (bus_a.wbs_readdata !== 16'h0042) $display("FAIL readdata_hold: got %h expected 0042", bus_a.wbs_readdata); else n_pass++;
        sb.push_back('{16'h00F1, 2});
        do_txn(0, 1'b0, 16'h1000, 16'h0, rd, lat);
        e = sb.pop_front();
        n_checks++; if (rd !== e.data) $display("FAIL ctrl_unused_bits: got %h expected %h", rd, e.data); else n_pass++;
    endtask

    task automatic test_held_strobe();
        int pc, ac;
        pc = pix_cnt[0];
        ac = ack_cnt[0];
        @(posedge clk); #1;
        set_bus(0, 1'b1, 1'b1, 1'b1, 16'h0200, 16'h0555);
        repeat (10) @(posedge clk);
        #1 set_bus(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (3) @(posedge clk);
        n_checks++; if (pix_cnt[0] - pc != 1 || ack_cnt[0] - ac != 1)
            $display("FAIL held_strobe: got pulses %0d acks %0d expected 1 1", pix_cnt[0] - pc, ack_cnt[0] - ac); else n_pass++;
    endtask

    task automatic test_mid_drop();
        logic [15:0] rd;
        int lat, ac;
        bit seen;
        exp_t e;
        ac = ack_cnt[1];
        sb.push_back('{16'h0ABC, 0});
        @(posedge clk); #1;
        set_bus(1, 1'b1, 1'b1, 1'b0, 16'h0123, 16'h0);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); if (mem_r_en_b) seen = 1; end
        @(posedge clk); #1;
        set_bus(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); if (bus_b.wbs_ack) seen = 1; end
        e = sb.pop_front();
        n_checks++; if (!seen || bus_b.wbs_readdata !== e.data)
            $display("FAIL mid_drop: got ack %0d data %h expected 1 %h", seen, bus_b.wbs_readdata, e.data); else n_pass++;
        sb.push_back('{16'h0000, 2});
        do_txn(1, 1'b0, 16'h1003, 16'h0, rd, lat);
        e = sb.pop_front();
        n_checks++; if (rd !== e.data || lat != e.lat || ack_cnt[1] - ac != 2)
            $display("FAIL mid_drop_next: got %h lat %0d acks %0d expected %h lat %0d acks 2", rd, lat, ack_cnt[1] - ac, e.data, e.lat); else n_pass++;
    endtask

    task automatic test_reset_in_mem_wait();
        logic [15:0] rd;
        int lat, ac;
        bit seen;
        exp_t e;
        @(posedge clk); #1;
        set_bus(1, 1'b1, 1'b1, 1'b0, 16'h0123, 16'h0);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); if (mem_r_en_b) seen = 1; end
        ac = ack_cnt[1];
        @(posedge clk); #1;
        gls_reset = 1'b1;
        set_bus(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge clk); #1;
        gls_reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        n_checks++; if (!seen || ack_cnt[1] != ac) $display("FAIL rst_mem_wait_ack: got launch %0d acks %0d expected 1 0", seen, ack_cnt[1] - ac); else n_pass++;
        n_checks++; if (bus_b.wbs_readdata !== 16'h0 || ctrl_bright_b !== 4'hF)
            $display("FAIL rst_mem_wait_regs: got %h %h expected 0000 f", bus_b.wbs_readdata, ctrl_bright_b); else n_pass++;
        sb.push_back('{16'h0FFF, 5});
        do_txn(1, 1'b0, 16'h0FFF, 16'h0, rd, lat);
        e = sb.pop_front();
        n_checks++; if (rd !== e.data || lat != e.lat) $display("FAIL rst_mem_wait_next: got %h lat %0d expected %h lat %0d", rd, lat, e.data, e.lat); else n_pass++;
    endtask

    initial begin
        set_bus(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_bus(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        test_reset();
        test_pixel_write(0);
        test_pixel_write(1);
        test_pixel_read(0);
        test_pixel_read(1);
        test_registers();
        test_held_strobe();
        test_mid_drop();
        test_reset_in_mem_wait();
        n_checks++; if (overlap_cnt != 0) $display("FAIL en_overlap: got %0d expected 0", overlap_cnt); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
